pulse_dispatch: RTL and testbench

PULSE_DISPATCH -- requirements
Module: pulse_dispatch

---
 rtl/pulse_dispatch_pkg.sv | 21 ++
 rtl/dispatch_fifo.sv | 50 +++++
 rtl/pulse_dispatch.sv | 174 +++++++++++++++++
 tb/tb_pulse_dispatch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_dispatch_pkg.sv
// Default widths and per-channel FSM state for the pulse dispatcher.
package pulse_dispatch_pkg;

  localparam int unsigned DEF_N_CHAN      = 3;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_CHAN_SEL_W  = 2;
  localparam int unsigned DEF_ENV_WIDTH   = 24;
  localparam int unsigned DEF_ENV_ADDR_W  = 12;
  localparam int unsigned DEF_PHASE_WIDTH = 17;
  localparam int unsigned DEF_FREQ_WIDTH  = 9;
  localparam int unsigned DEF_AMP_WIDTH   = 16;
  localparam int unsigned DEF_CFG_WIDTH   = 4;
  localparam int unsigned DEF_BUSY_LAT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/dispatch_fifo.sv
// Single-clock command FIFO with synchronous flush; read data is the head entry.
module dispatch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign rdata_c = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wr_ptr] <= wdata;
  end

  // Caller guarantees no write when full (unless popping) and no read when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !rd)      count <= count + (AW+1)'(1);
      else if (!wr && rd) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pulse_dispatch.sv
// Routes processor pulse commands into per-channel FIFOs and issues them to
// the pulse elements one at a time, honouring each element's busy handshake.
module pulse_dispatch
  import pulse_dispatch_pkg::*;
#(
  parameter int unsigned N_CHAN      = DEF_N_CHAN,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned CHAN_SEL_W  = DEF_CHAN_SEL_W,
  parameter int unsigned ENV_WIDTH   = DEF_ENV_WIDTH,
  parameter int unsigned ENV_ADDR_W  = DEF_ENV_ADDR_W,
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int unsigned FREQ_WIDTH  = DEF_FREQ_WIDTH,
  parameter int unsigned AMP_WIDTH   = DEF_AMP_WIDTH,
  parameter int unsigned CFG_WIDTH   = DEF_CFG_WIDTH,
  parameter int unsigned BUSY_LAT    = DEF_BUSY_LAT
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         cstrobe,
  input  logic                                         pulse_reset,
  input  logic [CFG_WIDTH-1:0]                         cfg,
  input  logic [ENV_WIDTH-1:0]                         env_word,
  input  logic [AMP_WIDTH-1:0]                         amp,
  input  logic [FREQ_WIDTH-1:0]                        freq,
  input  logic [PHASE_WIDTH-1:0]                       phase,
  input  logic                                         proc_done,
  input  logic [N_CHAN-1:0]                            elem_busy,
  output logic [N_CHAN-1:0]                            elem_cmdstb,
  output logic [N_CHAN-1:0]                            elem_reset,
  output logic [N_CHAN*ENV_ADDR_W-1:0]                 elem_envstart,
  output logic [N_CHAN*ENV_ADDR_W-1:0]                 elem_envlength,
  output logic [N_CHAN*AMP_WIDTH-1:0]                  elem_amp,
  output logic [N_CHAN*FREQ_WIDTH-1:0]                 elem_freq,
  output logic [N_CHAN*PHASE_WIDTH-1:0]                elem_phase,
  output logic [N_CHAN*(CFG_WIDTH-CHAN_SEL_W)-1:0]     elem_mode,
  output logic [N_CHAN-1:0]                            overflow,
  output logic                                         bad_chan,
  output logic                                         done
);

  localparam int unsigned MODE_W = CFG_WIDTH - CHAN_SEL_W;
  localparam int unsigned EXT_W  = 2 * ENV_ADDR_W;
  localparam int unsigned CMD_W  = EXT_W + AMP_WIDTH + FREQ_WIDTH + PHASE_WIDTH + MODE_W;
  localparam int unsigned CNT_W  = (BUSY_LAT > 1) ? $clog2(BUSY_LAT) : 1;

  logic [CHAN_SEL_W-1:0] chan_c;
  logic                  bad_c;
  logic                  accept_c;
  logic [EXT_W-1:0]      env_ext;
  logic [CMD_W-1:0]      cmd_in;
  logic [N_CHAN-1:0]     chan_quiet;

  assign chan_c   = cfg[CHAN_SEL_W-1:0];
  assign bad_c    = (32'(chan_c) >= N_CHAN);
  assign accept_c = cstrobe && !pulse_reset;

  // Envelope word is {length, start}; pad or trim to exactly two address fields.
  if (ENV_WIDTH >= EXT_W) begin : g_env_trim
    assign env_ext = env_word[EXT_W-1:0];
  end else begin : g_env_pad
    assign env_ext = {{(EXT_W-ENV_WIDTH){1'b0}}, env_word};
  end

  assign cmd_in = {env_ext, amp, freq, phase, cfg[CFG_WIDTH-1:CHAN_SEL_W]};

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    logic              sel_c;
    logic              wr_c;
    logic              pop_c;
    logic              full;
    logic              empty;
    logic [CMD_W-1:0]  rdata_c;
    chan_state_e       state_q;
    chan_state_e       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              stb_q;
    logic              ovf_q;
    logic [ENV_ADDR_W-1:0]  start_q;
    logic [ENV_ADDR_W-1:0]  len_q;
    logic [AMP_WIDTH-1:0]   amp_q;
    logic [FREQ_WIDTH-1:0]  freq_q;
    logic [PHASE_WIDTH-1:0] phase_q;
    logic [MODE_W-1:0]      mode_q;

    assign sel_c = accept_c && !bad_c && (32'(chan_c) == c);
    assign pop_c = (state_q == ST_IDLE) && !empty && !elem_busy[c] && !pulse_reset;
    assign wr_c  = sel_c && (!full || pop_c);

    dispatch_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (pulse_reset),
      .wr      (wr_c),
      .wdata   (cmd_in),
      .rd      (pop_c),
      .rdata_c (rdata_c),
      .full    (full),
      .empty   (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // WAIT ignores busy until the element has had BUSY_LAT cycles to raise it.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_IDLE:  if (pop_c) state_d = ST_ISSUE;
        ST_ISSUE: begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(BUSY_LAT - 1);
        end
        ST_WAIT: begin
          if (cnt_q != '0)        cnt_d   = cnt_q - CNT_W'(1);
          else if (!elem_busy[c]) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (pulse_reset) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stb_q   <= 1'b0;
        ovf_q   <= 1'b0;
        start_q <= '0;
        len_q   <= '0;
        amp_q   <= '0;
        freq_q  <= '0;
        phase_q <= '0;
        mode_q  <= '0;
      end else begin
        stb_q <= pop_c;
        if (pop_c) {len_q, start_q, amp_q, freq_q, phase_q, mode_q} <= rdata_c;
        if (sel_c && full && !pop_c) ovf_q <= 1'b1;
      end
    end

    assign chan_quiet[c]                                = empty && (state_q == ST_IDLE);
    assign elem_cmdstb[c]                               = stb_q;
    assign overflow[c]                                  = ovf_q;
    assign elem_envstart[c*ENV_ADDR_W +: ENV_ADDR_W]    = start_q;
    assign elem_envlength[c*ENV_ADDR_W +: ENV_ADDR_W]   = len_q;
    assign elem_amp[c*AMP_WIDTH +: AMP_WIDTH]           = amp_q;
    assign elem_freq[c*FREQ_WIDTH +: FREQ_WIDTH]        = freq_q;
    assign elem_phase[c*PHASE_WIDTH +: PHASE_WIDTH]     = phase_q;
    assign elem_mode[c*MODE_W +: MODE_W]                = mode_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elem_reset <= '0;
      bad_chan   <= 1'b0;
      done       <= 1'b0;
    end else begin
      elem_reset <= {N_CHAN{pulse_reset}};
      if (accept_c && bad_c) bad_chan <= 1'b1;
      done <= proc_done && (&chan_quiet) && !(|elem_busy);
    end
  end

endmodule

// File: tb/tb_pulse_dispatch.sv
// Directed, table-driven bench for pulse_dispatch with default parameters.
module tb_pulse_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        cstrobe;
  logic        pulse_reset;
  logic [3:0]  cfg;
  logic [23:0] env_word;
  logic [15:0] amp;
  logic [8:0]  freq;
  logic [16:0] phase;
  logic        proc_done;
  logic [2:0]  elem_busy;
  logic [2:0]  elem_cmdstb;
  logic [2:0]  elem_reset;
  logic [35:0] elem_envstart;
  logic [35:0] elem_envlength;
  logic [47:0] elem_amp;
  logic [26:0] elem_freq;
  logic [50:0] elem_phase;
  logic [5:0]  elem_mode;
  logic [2:0]  overflow;
  logic        bad_chan;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_dispatch dut (
    .clk            (clk),
    .reset          (reset),
    .cstrobe        (cstrobe),
    .pulse_reset    (pulse_reset),
    .cfg            (cfg),
    .env_word       (env_word),
    .amp            (amp),
    .freq           (freq),
    .phase          (phase),
    .proc_done      (proc_done),
    .elem_busy      (elem_busy),
    .elem_cmdstb    (elem_cmdstb),
    .elem_reset     (elem_reset),
    .elem_envstart  (elem_envstart),
    .elem_envlength (elem_envlength),
    .elem_amp       (elem_amp),
    .elem_freq      (elem_freq),
    .elem_phase     (elem_phase),
    .elem_mode      (elem_mode),
    .overflow       (overflow),
    .bad_chan       (bad_chan),
    .done           (done)
  );

  typedef struct {
    logic [3:0]  cfg;
    logic [23:0] env;
    logic [15:0] amp;
    logic [8:0]  freq;
    logic [16:0] phase;
    int          ch;
    logic [2:0]  exp_stb;
    logic [11:0] exp_start;
    logic [11:0] exp_len;
    logic [1:0]  exp_mode;
    logic        exp_bad;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] fields(input int ch);
    return {elem_envstart[ch*12 +: 12], elem_envlength[ch*12 +: 12], elem_amp[ch*16 +: 16],
            elem_freq[ch*9 +: 9], elem_phase[ch*17 +: 17], elem_mode[ch*2 +: 2]};
  endfunction

  task automatic drive(input logic [3:0] c, input logic [23:0] e, input logic [15:0] a,
                       input logic [8:0] f, input logic [16:0] p);
    cstrobe  = 1'b1;
    cfg      = c;
    env_word = e;
    amp      = a;
    freq     = f;
    phase    = p;
  endtask

  initial begin
    logic [15:0] seen [$];
    int          strobes;

    vecs[0] = '{4'b0101, 24'h040010, 16'h1234, 9'h055, 17'h1ABCD, 1, 3'b010, 12'h010, 12'h040, 2'b01, 1'b0};
    vecs[1] = '{4'b1000, 24'hFFF001, 16'hBEEF, 9'h1FF, 17'h00001, 0, 3'b001, 12'h001, 12'hFFF, 2'b10, 1'b0};
    vecs[2] = '{4'b1110, 24'h123456, 16'h0001, 9'h100, 17'h1FFFF, 2, 3'b100, 12'h456, 12'h123, 2'b11, 1'b0};
    vecs[3] = '{4'b0011, 24'hAAAAAA, 16'h5555, 9'h0AA, 17'h15555, 0, 3'b000, 12'h000, 12'h000, 2'b00, 1'b1};
    vecs[4] = '{4'b0001, 24'h000FFF, 16'hFFFF, 9'h000, 17'h00000, 1, 3'b010, 12'hFFF, 12'h000, 2'b00, 1'b1};

    reset = 1'b1; cstrobe = 1'b0; pulse_reset = 1'b0; cfg = '0; env_word = '0;
    amp = '0; freq = '0; phase = '0; proc_done = 1'b0; elem_busy = '0;
    step(); step();
    check("reset_stb", 128'(elem_cmdstb), 128'(0));
    check("reset_fields", 128'({elem_envstart, elem_amp}), 128'(0));
    check("reset_flags", 128'({overflow, bad_chan, done, elem_reset}), 128'(0));
    reset = 1'b0;
    step();

    // Single commands into an idle dispatcher: strobe lands two cycles later.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].cfg, vecs[i].env, vecs[i].amp, vecs[i].freq, vecs[i].phase);
      step();
      cstrobe = 1'b0;
      check($sformatf("v%0d_early", i), 128'(elem_cmdstb), 128'(0));
      step();
      check($sformatf("v%0d_stb", i), 128'(elem_cmdstb), 128'(vecs[i].exp_stb));
      if (vecs[i].exp_stb != 3'b000)
        check($sformatf("v%0d_fields", i), 128'(fields(vecs[i].ch)),
              128'({vecs[i].exp_start, vecs[i].exp_len, vecs[i].amp, vecs[i].freq,
                    vecs[i].phase, vecs[i].exp_mode}));
      check($sformatf("v%0d_bad", i), 128'(bad_chan), 128'(vecs[i].exp_bad));
      step();
      check($sformatf("v%0d_one_cycle", i), 128'(elem_cmdstb), 128'(0));
      step(); step(); step();
    end
    check("hold_ch0", 128'(fields(0)), 128'({12'h001, 12'hFFF, 16'hBEEF, 9'h1FF, 17'h00001, 2'b10}));
    check("no_ovf_yet", 128'(overflow), 128'(0));

    // Five back-to-back commands to a busy channel 0: four fit, one overflows.
    elem_busy = 3'b001;
    for (int i = 1; i <= 5; i++) begin
      drive(4'b0000, 24'h0, 16'(i), 9'h0, 17'h0);
      step();
    end
    cstrobe = 1'b0;
    check("ovf_flag", 128'(overflow), 128'(3'b001));
    check("ovf_no_stb", 128'(elem_cmdstb), 128'(0));
    elem_busy = 3'b000;
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (elem_cmdstb[0]) begin
        seen.push_back(elem_amp[15:0]);
        strobes++;
      end
    end
    check("drain_count", 128'(strobes), 128'(4));
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_order%0d", i), 128'(i < seen.size() ? seen[i] : 16'hXXXX), 128'(i + 1));

    // Two channels released together issue in the same cycle.
    elem_busy = 3'b101;
    drive(4'b0100, 24'h000111, 16'hA0A0, 9'h011, 17'h00111); step();
    drive(4'b0110, 24'h000222, 16'hC0C0, 9'h022, 17'h00222); step();
    cstrobe = 1'b0;
    step();
    elem_busy = 3'b000;
    for (int i = 0; i < 10; i++) begin
      if (elem_cmdstb != 3'b000) break;
      step();
    end
    check("parallel_stb", 128'(elem_cmdstb), 128'(3'b101));
    check("parallel_amp", 128'({elem_amp[47:32], elem_amp[15:0]}), 128'({16'hC0C0, 16'hA0A0}));
    step(); step(); step(); step();

    // Flush three queued commands on channel 1, then confirm done.
    elem_busy = 3'b010;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 24'h0, 16'h7000 + 16'(i), 9'h0, 17'h0);
      step();
    end
    cstrobe = 1'b0;
    pulse_reset = 1'b1;
    drive(4'b0001, 24'h0, 16'h7777, 9'h0, 17'h0);
    step();
    pulse_reset = 1'b0;
    cstrobe = 1'b0;
    check("flush_elem_reset", 128'(elem_reset), 128'(3'b111));
    step();
    check("flush_reset_pulse", 128'(elem_reset), 128'(3'b000));
    check("flush_sticky", 128'({overflow, bad_chan}), 128'({3'b001, 1'b1}));
    elem_busy = 3'b000;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (elem_cmdstb != 3'b000) strobes++;
    end
    check("flush_no_stb", 128'(strobes), 128'(0));
    check("done_low", 128'(done), 128'(0));
    proc_done = 1'b1;
    step();
    check("done_high", 128'(done), 128'(1));
    elem_busy = 3'b100;
    step();
    check("done_busy", 128'(done), 128'(0));
    elem_busy = 3'b000;
    step();

    // Asynchronous reset while a strobe is on the wire.
    drive(4'b0000, 24'h0000AB, 16'h00AB, 9'h0AB, 17'h000AB); step();
    drive(4'b0000, 24'h0000CD, 16'h00CD, 9'h0CD, 17'h000CD); step();
    cstrobe = 1'b0;
    check("pre_reset_stb", 128'(elem_cmdstb), 128'(3'b001));
    reset = 1'b1;
    #1;
    check("async_stb", 128'(elem_cmdstb), 128'(0));
    check("async_outs", 128'({elem_envstart, elem_amp, elem_phase}), 128'(0));
    check("async_flags", 128'({overflow, bad_chan, done, elem_reset}), 128'(0));
    step();
    reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (elem_cmdstb != 3'b000) strobes++;
    end
    check("queue_lost", 128'(strobes), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
